// File: rtl/pa_fdsu_pack_pipe.sv
// FDSU result-pack stage: two-entry valid/ready pipeline that packs the rounded fraction/exponent into an IEEE word plus fflags.
// Optional sticky fflags accumulator enabled by defining FDSU_PACK_FFLAGS_ACC_EN.
module pa_fdsu_pack_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst_b,
  input  logic                      pack_in_vld,
  output logic                      pack_in_rdy,
  input  logic [FRAC_W+2:0]         pack_in_frac,
  input  logic [EXP_W+1:0]          pack_in_expnt,
  input  logic                      pack_in_sign,
  input  logic                      pack_in_nx,
  input  logic                      pack_in_of,
  input  logic                      pack_in_uf,
  input  logic                      pack_in_potnt_of,
  input  logic                      pack_in_potnt_uf,
  input  logic                      pack_in_result_nor,
  input  logic                      pack_in_of_rm_lfn,
  input  logic                      pack_in_result_inf,
  input  logic                      pack_in_result_lfn,
  input  logic                      pack_in_rslt_denorm,
  input  logic                      pack_in_denorm_to_tiny,
  input  logic [1:0]                pack_in_potnt_norm,
  input  logic [4:0]                pack_in_freg,
  input  logic                      pack_flush,
  output logic                      pack_out_vld,
  input  logic                      pack_out_rdy,
  output logic [EXP_W+FRAC_W:0]     pack_out_data,
  output logic [4:0]                pack_out_fflags,
  output logic [4:0]                pack_out_freg
`ifdef FDSU_PACK_FFLAGS_ACC_EN
  ,
  output logic [4:0]                pack_fflags_acc,
  input  logic                      pack_fflags_clr
`endif
);

  logic [1:0]              w_top2;
  logic signed [EXP_W+1:0] w_expnt_s;
  logic signed [31:0]      w_e_s;
  logic [31:0]             w_shamt;
  logic                    w_dn_in_range;
  logic [EXP_W-1:0]        w_adj;
  logic [FRAC_W-1:0]       w_norm_frac;
  logic [FRAC_W-1:0]       w_dn_frac;
  logic                    w_dpn;
  logic                    w_of_plus;
  logic                    w_uf_plus;
  logic                    w_s1_xfer;
  logic                    w_s2_load;
  logic [EXP_W+FRAC_W:0]   w_s2_data;
  logic [4:0]              w_s2_fflags;

  logic                    r_s1_vld;
  logic                    r_s1_sign;
  logic                    r_s1_nx;
  logic                    r_s1_of;
  logic                    r_s1_uf;
  logic                    r_s1_dpn;
  logic                    r_s1_rslt_denorm;
  logic                    r_s1_of_plus;
  logic                    r_s1_uf_plus;
  logic                    r_s1_inf;
  logic                    r_s1_lfn;
  logic [EXP_W-1:0]        r_s1_adj;
  logic [FRAC_W-1:0]       r_s1_norm_frac;
  logic [FRAC_W-1:0]       r_s1_dn_frac;
  logic [4:0]              r_s1_freg;

  logic                    r_s2_vld;
  logic [EXP_W+FRAC_W:0]   r_s2_data;
  logic [4:0]              r_s2_fflags;
  logic [4:0]              r_s2_freg;

  assign w_top2    = pack_in_frac[FRAC_W+2:FRAC_W+1];
  assign w_expnt_s = $signed(pack_in_expnt);
  assign w_e_s     = 32'(w_expnt_s);

  // Adjusted exponent only needs the low EXP_W bits; modulo arithmetic keeps them exact.
  always_comb begin
    w_adj       = pack_in_expnt[EXP_W-1:0];
    w_norm_frac = pack_in_frac[FRAC_W+1:2];
    case (w_top2)
      2'b00: begin
        w_adj       = pack_in_expnt[EXP_W-1:0] - EXP_W'(1);
        w_norm_frac = pack_in_frac[FRAC_W-1:0];
      end
      2'b01: begin
        w_adj       = pack_in_expnt[EXP_W-1:0];
        w_norm_frac = pack_in_frac[FRAC_W:1];
      end
      default: begin
        w_adj       = pack_in_expnt[EXP_W-1:0] + EXP_W'(1);
        w_norm_frac = pack_in_frac[FRAC_W+1:2];
      end
    endcase
  end

  // Denormal shift uses the unadjusted exponent; out-of-range exponents flush to 0 or min subnormal.
  assign w_dn_in_range = (w_e_s >= (1 - FRAC_W)) && (w_e_s <= 1);
  assign w_shamt       = 32'(2 - w_e_s);

  always_comb begin
    w_dn_frac = pack_in_denorm_to_tiny ? FRAC_W'(1) : '0;
    if (w_dn_in_range)
      w_dn_frac = FRAC_W'(pack_in_frac >> w_shamt);
  end

  assign w_dpn     = (pack_in_potnt_norm[1] & pack_in_frac[FRAC_W+1])
                   | (pack_in_potnt_norm[0] & pack_in_frac[FRAC_W+2]);
  assign w_of_plus = pack_in_potnt_of & (|w_top2) & pack_in_result_nor;
  assign w_uf_plus = pack_in_potnt_uf & ~(|w_top2) & pack_in_result_nor;

  assign w_s2_load   = ~r_s2_vld | pack_out_rdy;
  assign pack_in_rdy = ~r_s1_vld | w_s2_load;
  assign w_s1_xfer   = pack_in_vld & pack_in_rdy;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else if (pack_flush) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
    end else begin
      if (pack_in_rdy)
        r_s1_vld <= pack_in_vld;
      if (w_s2_load)
        r_s2_vld <= r_s1_vld;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_s1_sign        <= 1'b0;
      r_s1_nx          <= 1'b0;
      r_s1_of          <= 1'b0;
      r_s1_uf          <= 1'b0;
      r_s1_dpn         <= 1'b0;
      r_s1_rslt_denorm <= 1'b0;
      r_s1_of_plus     <= 1'b0;
      r_s1_uf_plus     <= 1'b0;
      r_s1_inf         <= 1'b0;
      r_s1_lfn         <= 1'b0;
      r_s1_adj         <= '0;
      r_s1_norm_frac   <= '0;
      r_s1_dn_frac     <= '0;
      r_s1_freg        <= '0;
    end else if (w_s1_xfer) begin
      r_s1_sign        <= pack_in_sign;
      r_s1_nx          <= pack_in_nx;
      r_s1_of          <= pack_in_of;
      r_s1_uf          <= pack_in_uf;
      r_s1_dpn         <= w_dpn;
      r_s1_rslt_denorm <= pack_in_rslt_denorm & ~w_dpn;
      r_s1_of_plus     <= w_of_plus;
      r_s1_uf_plus     <= w_uf_plus;
      r_s1_inf         <= (w_of_plus & ~pack_in_of_rm_lfn) | pack_in_result_inf;
      r_s1_lfn         <= (w_of_plus & pack_in_of_rm_lfn) | pack_in_result_lfn;
      r_s1_adj         <= w_adj;
      r_s1_norm_frac   <= w_norm_frac;
      r_s1_dn_frac     <= w_dn_frac;
      r_s1_freg        <= pack_in_freg;
    end
  end

  // Special-result priority: inf over lfn over denormal over normal.
  always_comb begin
    w_s2_data = {r_s1_sign, r_s1_adj, r_s1_norm_frac};
    if (r_s1_inf)
      w_s2_data = {r_s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (r_s1_lfn)
      w_s2_data = {r_s1_sign, {{(EXP_W-1){1'b1}}, 1'b0}, {FRAC_W{1'b1}}};
    else if (r_s1_rslt_denorm)
      w_s2_data = {r_s1_sign, {EXP_W{1'b0}}, r_s1_dn_frac};
  end

  assign w_s2_fflags = {2'b00,
                        r_s1_of | r_s1_of_plus,
                        ((r_s1_uf & ~r_s1_dpn) | r_s1_uf_plus) & r_s1_nx,
                        r_s1_nx | r_s1_of | r_s1_of_plus};

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      r_s2_data   <= '0;
      r_s2_fflags <= '0;
      r_s2_freg   <= '0;
    end else if (r_s1_vld && w_s2_load) begin
      r_s2_data   <= w_s2_data;
      r_s2_fflags <= w_s2_fflags;
      r_s2_freg   <= r_s1_freg;
    end
  end

  assign pack_out_vld    = r_s2_vld;
  assign pack_out_data   = r_s2_data;
  assign pack_out_fflags = r_s2_fflags;
  assign pack_out_freg   = r_s2_freg;

`ifdef FDSU_PACK_FFLAGS_ACC_EN
  logic       w_out_xfer;
  logic [4:0] r_fflags_acc;

  assign w_out_xfer = r_s2_vld & pack_out_rdy;

  // A clear coinciding with a transfer leaves exactly that transfer's flags.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b)
      r_fflags_acc <= '0;
    else if (pack_fflags_clr)
      r_fflags_acc <= w_out_xfer ? r_s2_fflags : 5'b00000;
    else if (w_out_xfer)
      r_fflags_acc <= r_fflags_acc | r_s2_fflags;
  end

  assign pack_fflags_acc = r_fflags_acc;
`endif

endmodule

// File: tb/tb_pa_fdsu_pack_pipe.sv
// Directed bench for pa_fdsu_pack_pipe: single-precision and half-precision instances.
// Sticky-flag checks run only when FDSU_PACK_FFLAGS_ACC_EN is defined.
module tb_pa_fdsu_pack_pipe;

  logic        clk;
  logic        rst_b;
  logic        vld, in_rdy, flush, out_vld, out_rdy;
  logic [25:0] frac;
  logic [9:0]  expnt;
  logic        sign, nx, of, uf, potnt_of, potnt_uf, result_nor;
  logic        of_rm_lfn, result_inf, result_lfn, rslt_denorm, dn_tiny;
  logic [1:0]  potnt_norm;
  logic [4:0]  freg, out_fflags, out_freg;
  logic [31:0] out_data;
  logic [4:0]  acc;
  logic        acc_clr;

  logic        h_vld, h_in_rdy, h_out_vld;
  logic [12:0] h_frac;
  logic [6:0]  h_expnt;
  logic        h_rdn, h_tiny;
  logic [15:0] h_data;
  logic [4:0]  h_fflags, h_freg;
  logic [4:0]  h_acc;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pa_fdsu_pack_pipe u_dut (
    .forever_cpuclk        (clk),
    .cpurst_b              (rst_b),
    .pack_in_vld           (vld),
    .pack_in_rdy           (in_rdy),
    .pack_in_frac          (frac),
    .pack_in_expnt         (expnt),
    .pack_in_sign          (sign),
    .pack_in_nx            (nx),
    .pack_in_of            (of),
    .pack_in_uf            (uf),
    .pack_in_potnt_of      (potnt_of),
    .pack_in_potnt_uf      (potnt_uf),
    .pack_in_result_nor    (result_nor),
    .pack_in_of_rm_lfn     (of_rm_lfn),
    .pack_in_result_inf    (result_inf),
    .pack_in_result_lfn    (result_lfn),
    .pack_in_rslt_denorm   (rslt_denorm),
    .pack_in_denorm_to_tiny(dn_tiny),
    .pack_in_potnt_norm    (potnt_norm),
    .pack_in_freg          (freg),
    .pack_flush            (flush),
    .pack_out_vld          (out_vld),
    .pack_out_rdy          (out_rdy),
    .pack_out_data         (out_data),
    .pack_out_fflags       (out_fflags),
    .pack_out_freg         (out_freg)
`ifdef FDSU_PACK_FFLAGS_ACC_EN
    ,
    .pack_fflags_acc       (acc),
    .pack_fflags_clr       (acc_clr)
`endif
  );

  pa_fdsu_pack_pipe #(.EXP_W(5), .FRAC_W(10)) u_dut_h (
    .forever_cpuclk        (clk),
    .cpurst_b              (rst_b),
    .pack_in_vld           (h_vld),
    .pack_in_rdy           (h_in_rdy),
    .pack_in_frac          (h_frac),
    .pack_in_expnt         (h_expnt),
    .pack_in_sign          (1'b0),
    .pack_in_nx            (1'b0),
    .pack_in_of            (1'b0),
    .pack_in_uf            (1'b0),
    .pack_in_potnt_of      (1'b0),
    .pack_in_potnt_uf      (1'b0),
    .pack_in_result_nor    (1'b0),
    .pack_in_of_rm_lfn     (1'b0),
    .pack_in_result_inf    (1'b0),
    .pack_in_result_lfn    (1'b0),
    .pack_in_rslt_denorm   (h_rdn),
    .pack_in_denorm_to_tiny(h_tiny),
    .pack_in_potnt_norm    (2'b00),
    .pack_in_freg          (5'd0),
    .pack_flush            (1'b0),
    .pack_out_vld          (h_out_vld),
    .pack_out_rdy          (1'b1),
    .pack_out_data         (h_data),
    .pack_out_fflags       (h_fflags),
    .pack_out_freg         (h_freg)
`ifdef FDSU_PACK_FFLAGS_ACC_EN
    ,
    .pack_fflags_acc       (h_acc),
    .pack_fflags_clr       (1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    vld = 0; frac = '0; expnt = '0; sign = 0; nx = 0; of = 0; uf = 0;
    potnt_of = 0; potnt_uf = 0; result_nor = 0; of_rm_lfn = 0;
    result_inf = 0; result_lfn = 0; rslt_denorm = 0; dn_tiny = 0;
    potnt_norm = 2'b00; freg = '0;
  endtask

  // Presents one op, checks the 2-cycle latency and the packed result, then drains it.
  task automatic run_one(input string tag, input logic [31:0] e_data, input logic [4:0] e_flags,
                         input logic [4:0] e_freg);
    vld = 1;
    tick();
    vld = 0;
    chk({tag, "_lat1"}, out_vld, 0);
    tick();
    chk({tag, "_vld"}, out_vld, 1);
    chk({tag, "_data"}, out_data, e_data);
    chk({tag, "_flags"}, out_fflags, e_flags);
    chk({tag, "_freg"}, out_freg, e_freg);
    tick();
  endtask

  initial begin
    int sent;
    int got;
    rst_b = 0; flush = 0; out_rdy = 1; acc_clr = 0;
    h_vld = 0; h_frac = '0; h_expnt = '0; h_rdn = 0; h_tiny = 0;
    acc = '0; h_acc = '0;
    clr_in();
    tick(); tick();
    chk("rst_out_vld", out_vld, 0);
    chk("rst_data", out_data, 0);
    chk("rst_flags", out_fflags, 0);
    chk("rst_freg", out_freg, 0);
    chk("rst_in_rdy", in_rdy, 1);
`ifdef FDSU_PACK_FFLAGS_ACC_EN
    chk("rst_acc", acc, 0);
`endif
    rst_b = 1;
    tick();

    clr_in(); frac = 26'h1000000; expnt = 10'h07F; freg = 5'd3;
    run_one("norm1", 32'h3F800000, 5'b00000, 5'd3);
    clr_in(); frac = 26'h0800000; expnt = 10'h080; freg = 5'd4;
    run_one("adj00", 32'h3F800000, 5'b00000, 5'd4);
    clr_in(); frac = 26'h2000000; expnt = 10'h07E;
    run_one("adj1x", 32'h3F800000, 5'b00000, 5'd0);
    clr_in(); frac = 26'h1400000; expnt = 10'h07F;
    run_one("norm125", 32'h3FA00000, 5'b00000, 5'd0);

    clr_in(); frac = 26'h1000000; expnt = 10'h000; rslt_denorm = 1;
    run_one("dn", 32'h00400000, 5'b00000, 5'd0);
    clr_in(); frac = 26'h1000000; expnt = 10'h000; rslt_denorm = 1; uf = 1; nx = 1;
    run_one("dn_uf", 32'h00400000, 5'b00011, 5'd0);
    clr_in(); frac = 26'h1000000; expnt = 10'h3EA; rslt_denorm = 1;
    run_one("dn_lo_edge", 32'h00000001, 5'b00000, 5'd0);
    clr_in(); frac = 26'h1000000; expnt = 10'h3E9; rslt_denorm = 1;
    run_one("dn_out_zero", 32'h00000000, 5'b00000, 5'd0);
    clr_in(); frac = 26'h1000000; expnt = 10'h3E9; rslt_denorm = 1; dn_tiny = 1;
    run_one("dn_out_tiny", 32'h00000001, 5'b00000, 5'd0);
    clr_in(); frac = 26'h1000000; expnt = 10'h001; rslt_denorm = 1;
    potnt_norm = 2'b10; uf = 1; nx = 1;
    run_one("dpn", 32'h00800000, 5'b00001, 5'd0);

    clr_in(); frac = 26'h2000000; expnt = 10'h0FF; potnt_of = 1; result_nor = 1; nx = 1; sign = 1;
    run_one("of_inf", 32'hFF800000, 5'b00101, 5'd0);
    clr_in(); frac = 26'h2000000; expnt = 10'h0FF; potnt_of = 1; result_nor = 1; nx = 1; sign = 1;
    of_rm_lfn = 1;
    run_one("of_lfn", 32'hFF7FFFFF, 5'b00101, 5'd0);
    clr_in(); frac = 26'h1000000; expnt = 10'h07F; result_inf = 1; result_lfn = 1; rslt_denorm = 1;
    run_one("prio_inf", 32'h7F800000, 5'b00000, 5'd0);
    clr_in(); frac = 26'h0800000; expnt = 10'h001; potnt_uf = 1; result_nor = 1; nx = 1;
    run_one("uf_plus", 32'h00000000, 5'b00011, 5'd0);

    // Back-pressure: four back-to-back ops against a three-cycle stall.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      out_rdy = !(cyc >= 1 && cyc <= 3);
      clr_in();
      if (sent < 4) begin
        frac = 26'h1000000; expnt = 10'(10'h07F + sent); freg = 5'(sent + 1); vld = 1;
      end
      #1;
      if (cyc == 2) chk("bp_in_rdy_drop", in_rdy, 0);
      if (out_vld) begin
        chk("bp_data", out_data, 64'(32'h7F + got) << 23);
        chk("bp_freg", out_freg, got + 1);
        if (out_rdy) got++;
      end
      if (vld && in_rdy) sent++;
      tick();
    end
    clr_in(); out_rdy = 1;
    chk("bp_count", got, 4);

    // Flush: the op in flight and the op presented with the flush both vanish.
    clr_in(); frac = 26'h1000000; expnt = 10'h07F; freg = 5'd9; vld = 1;
    tick();
    freg = 5'd10; flush = 1;
    tick();
    clr_in(); flush = 0;
    chk("flush_vld0", out_vld, 0);
    tick();
    chk("flush_vld1", out_vld, 0);
    tick();
    chk("flush_vld2", out_vld, 0);
    clr_in(); frac = 26'h1000000; expnt = 10'h080; freg = 5'd11;
    run_one("post_flush", 32'h40000000, 5'b00000, 5'd11);

    // Reset mid-operation drops the op.
    clr_in(); frac = 26'h1000000; expnt = 10'h07F; freg = 5'd12; vld = 1;
    tick();
    clr_in(); rst_b = 0;
    tick();
    rst_b = 1;
    chk("midrst_vld", out_vld, 0);
    chk("midrst_data", out_data, 0);
    tick();
    chk("midrst_vld2", out_vld, 0);

`ifdef FDSU_PACK_FFLAGS_ACC_EN
    acc_clr = 1; tick(); acc_clr = 0;
    chk("acc_clr0", acc, 0);
    clr_in(); frac = 26'h1000000; expnt = 10'h07F; nx = 1;
    run_one("stk_nx", 32'h3F800000, 5'b00001, 5'd0);
    clr_in(); frac = 26'h1000000; expnt = 10'h07F; of = 1;
    run_one("stk_of", 32'h3F800000, 5'b00101, 5'd0);
    chk("acc_or", acc, 5'b00101);
    acc_clr = 1; tick(); acc_clr = 0;
    chk("acc_clr1", acc, 0);
`endif

    // Half precision instance.
    h_frac = 13'h0800; h_expnt = 7'h0F; h_vld = 1;
    tick();
    h_vld = 0;
    tick();
    chk("h_vld", h_out_vld, 1);
    chk("h_one", h_data, 16'h3C00);
    chk("h_flags", h_fflags, 0);
    chk("h_freg", h_freg, 0);
    chk("h_in_rdy", h_in_rdy, 1);
    tick();
    h_expnt = 7'h76; h_rdn = 1; h_tiny = 1; h_vld = 1;
    tick();
    h_vld = 0;
    tick();
    chk("h_tiny", h_data, 16'h0001);
    tick();
    h_frac = 13'h1000; h_expnt = 7'h77; h_rdn = 1; h_tiny = 0; h_vld = 1;
    tick();
    h_vld = 0;
    tick();
    chk("h_dn_edge", h_data, 16'h0002);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
